mem_read_port: RTL
==================

Name: mem_read_port

Overview:
- Read-side counterpart of the datapath's bus-loaded registers.
- Fetches one pixel from image memory at an internally held address into a memory data register (MDR), then presents it for driving onto the shared 18-bit datapath bus.
- Commanded by the control unit through rd_req, addr_ld and mdr_oe.
- Optionally auto-advances the address by a stride after each read, to walk the source image during down-sampling.

Parameters:
- DATA_W, 18: bus and address width.
- PIX_W, 8: memory read data width; zero-extended to DATA_W.
- MEM_LAT, 2: memory read latency in clocks, >=1.
- STRIDE, 2: auto-increment step applied to the address after a read.
- RST_ADDR, 0: reset value of the address register.

Ports:
- clk  in  1  datapath clock; all state updates on the falling edge, as in the rest of the datapath.
- rst  in  1  reset, asynchronous, active-high.
- en  in  1  command enable; gates rd_req and addr_ld only.
- addr_ld  in  1  load address register from bus_in.
- bus_in  in  DATA_W  datapath bus (address source).
- rd_req  in  1  start a memory read.
- inc  in  1  sampled with rd_req; 1 = advance address by STRIDE after capture.
- mdr_oe  in  1  request to drive the MDR onto the bus.
- mem_addr  out  DATA_W  memory address; equals the address register.
- mem_re  out  1  memory read strobe (registered).
- mem_rdata  in  PIX_W  memory read data.
- bus_out  out  DATA_W  MDR value.
- bus_oe  out  1  bus drive enable, = mdr_oe.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse after capture.

Behaviour:
- Async reset, immediate:
  - state = IDLE
  - addr_reg = RST_ADDR
  - mdr = 0
  - mem_re = 0, done = 0, busy = 0
  - inc_lat = 0, lat_cnt = 0
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If en & addr_ld: addr_reg <= bus_in.
  - If en & rd_req: go to ISSUE, inc_lat <= inc.
  - If addr_ld and rd_req arrive on the same edge, the read uses the newly loaded address.
- ISSUE, 1 cycle: mem_re = 1; mem_addr = addr_reg. Next state WAIT, lat_cnt <= MEM_LAT-1.
- WAIT, MEM_LAT cycles: mem_re = 0; lat_cnt decrements each edge.
- WAIT exit, on the edge where lat_cnt = 0:
  - mdr <= {zeros, mem_rdata}
  - if inc_lat: addr_reg <= addr_reg + STRIDE, modulo 2^DATA_W (wraps silently)
  - go to DONE.
- DONE, 1 cycle:
  - done = 1.
  - If en & rd_req: go to ISSUE (back-to-back read, capturing inc again); else go to IDLE.
  - addr_ld is honoured in DONE when no rd_req; if both are present, the load applies and the read uses the loaded address.
- Latency: with rd_req sampled at edge E0:
  - mem_re is high E0..E1.
  - Memory data must be valid at edge E1+MEM_LAT (capture).
  - done is high from E(MEM_LAT+1) to E(MEM_LAT+2).
  - Back-to-back throughput: one read per MEM_LAT+2 cycles.
- Ignored inputs:
  - rd_req and addr_ld in ISSUE or WAIT are ignored; nothing is queued and addr_reg is stable while busy.
  - en low never stalls an in-flight read; it only blocks new commands and loads.
- Bus drive: bus_out = mdr at all times; bus_oe = mdr_oe (combinational). While busy, bus_out holds the previous MDR until capture.
- Reset mid-read aborts the read: no done pulse, mdr cleared, mem_re dropped immediately.

Test Plan:
1. Reset: rst=1 mid-WAIT -> immediately state IDLE, mem_re=0, bus_out=0, mem_addr=0, busy=0, no done pulse afterwards.
2. Single read, MEM_LAT=2: addr_ld with bus_in=0x00100, then rd_req, inc=0 -> mem_re high for 1 cycle with mem_addr=0x00100; mem_rdata=0xA5 at capture edge -> bus_out=0x000A5; done pulses exactly 3 edges after rd_req sampled; mem_addr stays 0x00100.
3. Auto-increment with wrap: addr=0x3FFFF, inc=1, STRIDE=2 -> after done, mem_addr=0x00001; second read issues at 0x00001.
4. Back-to-back: rd_req held high, inc=1, start addr 0x10 -> reads issued at 0x10, 0x12, 0x14, spaced 4 cycles apart; one done pulse per read.
5. Ignored commands: rd_req and addr_ld (bus_in=0x2222) pulsed during WAIT -> no extra read, addr unchanged. Same-edge addr_ld=0x0050 plus rd_req in IDLE -> read at 0x0050.
6. en gating: en=0 with rd_req=1 in IDLE -> stays IDLE. en dropped during WAIT -> read completes and done pulses. mdr_oe=1 -> bus_oe=1 with bus_out equal to the MDR value.

Source files
------------

// File: rtl/mem_read_port.sv
// Read port between image memory and the datapath bus: fetches one pixel at the held address
// into the MDR, optionally steps the address by STRIDE, and drives the MDR onto the bus.
module mem_read_port #(
  parameter int unsigned        DATA_W   = 18,
  parameter int unsigned        PIX_W    = 8,
  parameter int unsigned        MEM_LAT  = 2,
  parameter int unsigned        STRIDE   = 2,
  parameter logic [DATA_W-1:0]  RST_ADDR = '0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic              i_addr_ld,
  input  logic [DATA_W-1:0] i_bus_in,
  input  logic              i_rd_req,
  input  logic              i_inc,
  input  logic              i_mdr_oe,
  output logic [DATA_W-1:0] o_mem_addr,
  output logic              o_mem_re,
  input  logic [PIX_W-1:0]  i_mem_rdata,
  output logic [DATA_W-1:0] o_bus_out,
  output logic              o_bus_oe,
  output logic              o_busy,
  output logic              o_done
);

  localparam int unsigned       LAT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [LAT_W-1:0]  LAT_LOAD = LAT_W'(MEM_LAT - 1);
  localparam logic [DATA_W-1:0] STEP     = DATA_W'(STRIDE);

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StDone
  } state_e;

  state_e             r_state, w_state_d;
  logic [DATA_W-1:0]  r_addr, w_addr_d;
  logic [DATA_W-1:0]  r_mdr, w_mdr_d;
  logic               r_inc, w_inc_d;
  logic [LAT_W-1:0]   r_lat_cnt, w_lat_cnt_d;
  logic               r_mem_re, w_mem_re_d;
  logic               r_done, w_done_d;
  logic               w_cmd_rd;
  logic               w_cmd_ld;

  assign w_cmd_rd = i_en & i_rd_req;
  assign w_cmd_ld = i_en & i_addr_ld;

  always_comb begin
    w_state_d   = r_state;
    w_addr_d    = r_addr;
    w_mdr_d     = r_mdr;
    w_inc_d     = r_inc;
    w_lat_cnt_d = r_lat_cnt;
    w_mem_re_d  = 1'b0;
    w_done_d    = 1'b0;
    case (r_state)
      // DONE accepts commands exactly like IDLE so reads can run back to back.
      StIdle, StDone: begin
        if (w_cmd_ld) begin
          w_addr_d = i_bus_in;
        end
        if (w_cmd_rd) begin
          w_state_d  = StIssue;
          w_inc_d    = i_inc;
          w_mem_re_d = 1'b1;
        end else begin
          w_state_d = StIdle;
        end
      end
      StIssue: begin
        w_state_d   = StWait;
        w_lat_cnt_d = LAT_LOAD;
      end
      StWait: begin
        if (r_lat_cnt == '0) begin
          w_mdr_d   = DATA_W'(i_mem_rdata);
          w_state_d = StDone;
          w_done_d  = 1'b1;
          if (r_inc) begin
            w_addr_d = r_addr + STEP;
          end
        end else begin
          w_lat_cnt_d = r_lat_cnt - 1'b1;
        end
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  // The rest of the datapath updates on the falling edge; this port follows suit.
  always_ff @(negedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= StIdle;
      r_addr    <= RST_ADDR;
      r_mdr     <= '0;
      r_inc     <= 1'b0;
      r_lat_cnt <= '0;
      r_mem_re  <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_addr    <= w_addr_d;
      r_mdr     <= w_mdr_d;
      r_inc     <= w_inc_d;
      r_lat_cnt <= w_lat_cnt_d;
      r_mem_re  <= w_mem_re_d;
      r_done    <= w_done_d;
    end
  end

  assign o_mem_addr = r_addr;
  assign o_mem_re   = r_mem_re;
  assign o_bus_out  = r_mdr;
  assign o_bus_oe   = i_mdr_oe;
  assign o_busy     = (r_state != StIdle);
  assign o_done     = r_done;

endmodule
